// File: rtl/stream_demux.sv
// stream_demux: one upstream valid/ready stream routed by in_sel
// into two independent 2-entry FIFOs (x and y), with per-queue word counters.
module stream_demux #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [n-1:0] in_data,
  input  logic         in_sel,
  output logic         in_ready,
  output logic         x_valid,
  output logic [n-1:0] x_data,
  input  logic         x_ready,
  output logic         y_valid,
  output logic [n-1:0] y_data,
  input  logic         y_ready,
  output logic [7:0]   x_count,
  output logic [7:0]   y_count
);

  localparam int DEPTH = 2;

  logic [n-1:0] xmem [DEPTH];
  logic [n-1:0] ymem [DEPTH];
  logic         xwp, xrp, ywp, yrp;
  logic [1:0]   xocc, yocc;
  logic         xfull, yfull;
  logic         xpush, xpop, ypush, ypop;

  assign xfull = (xocc == 2'd2);
  assign yfull = (yocc == 2'd2);

  // Readiness looks only at pre-edge occupancy; a full queue
  // cannot accept even if it pops on the same edge.
  assign in_ready = in_sel ? ~yfull : ~xfull;

  assign xpush = in_valid & in_ready & ~in_sel;
  assign ypush = in_valid & in_ready & in_sel;

  assign x_valid = (xocc != 2'd0);
  assign y_valid = (yocc != 2'd0);
  assign x_data  = xmem[xrp];
  assign y_data  = ymem[yrp];

  assign xpop = x_valid & x_ready;
  assign ypop = y_valid & y_ready;

  // x queue: storage, pointers, occupancy and accept counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xmem[0] <= '0;
      xmem[1] <= '0;
      xwp     <= 1'b0;
      xrp     <= 1'b0;
      xocc    <= 2'd0;
      x_count <= 8'd0;
    end else begin
      if (xpush) begin
        xmem[xwp] <= in_data;
        xwp       <= ~xwp;
        x_count   <= x_count + 8'd1;
      end
      if (xpop) xrp <= ~xrp;
      unique case (1'b1)
        xpush & ~xpop: xocc <= xocc + 2'd1;
        xpop & ~xpush: xocc <= xocc - 2'd1;
        default:       xocc <= xocc;
      endcase
    end
  end

  // y queue: storage, pointers, occupancy and accept counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ymem[0] <= '0;
      ymem[1] <= '0;
      ywp     <= 1'b0;
      yrp     <= 1'b0;
      yocc    <= 2'd0;
      y_count <= 8'd0;
    end else begin
      if (ypush) begin
        ymem[ywp] <= in_data;
        ywp       <= ~ywp;
        y_count   <= y_count + 8'd1;
      end
      if (ypop) yrp <= ~yrp;
      unique case (1'b1)
        ypush & ~ypop: yocc <= yocc + 2'd1;
        ypop & ~ypush: yocc <= yocc - 2'd1;
        default:       yocc <= yocc;
      endcase
    end
  end

endmodule
